// File: rtl/pc_predict.sv
// Fetch-PC predictor for a Y86-64 pipeline: predicts taken jumps, tracks calls
// on a circular return-address stack, and parks on RET misses and HALT.
module pc_predict #(
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           f_valid_i,
  input  logic [3:0]                     f_icode_i,
  input  logic [ADDR_W-1:0]              f_valC_i,
  input  logic [ADDR_W-1:0]              f_valP_i,
  input  logic                           stall_i,
  input  logic                           redirect_i,
  input  logic [ADDR_W-1:0]              redirect_pc_i,
  input  logic                           w_ret_i,
  input  logic [ADDR_W-1:0]              w_valM_i,
  output logic [ADDR_W-1:0]              pc_o,
  output logic                           halted_o,
  output logic                           ret_wait_o,
  output logic [$clog2(RAS_DEPTH):0]     ras_count_o
);

  localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // Y86-64 instruction codes
  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_predict: RAS_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_RET = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   top_q, top_d;   // next free slot; newest entry sits at top_q-1
  logic               push, pop;
  logic [ADDR_W-1:0]  ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0]  ras_top;

  assign ras_top = ras_q[top_q - PTR_W'(1)];

  // Next state, next PC and stack requests
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;

    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_WAIT_RET: begin
          if (w_ret_i) begin
            pc_d    = w_valM_i;
            state_d = ST_RUN;
          end
        end
        ST_HALT: ;
        default: begin
          if (f_valid_i && !stall_i) begin
            unique case (f_icode_i)
              I_HALT: state_d = ST_HALT;
              I_JXX:  pc_d    = f_valC_i;
              I_CALL: begin
                pc_d = f_valC_i;
                push = 1'b1;
              end
              I_RET: begin
                if (cnt_q != '0) begin
                  pc_d = ras_top;
                  pop  = 1'b1;
                end else begin
                  state_d = ST_WAIT_RET;
                end
              end
              default: pc_d = f_valP_i;
            endcase
          end
        end
      endcase
    end
  end

  // Stack bookkeeping; a push into a full stack silently drops the oldest entry
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      top_d = top_q + PTR_W'(1);
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      top_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
    end
  end

  // NOTE: stack storage has no reset; entries are only read when cnt_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) ras_q[top_q] <= f_valP_i;
  end

  assign pc_o        = pc_q;
  assign halted_o    = (state_q == ST_HALT);
  assign ret_wait_o  = (state_q == ST_WAIT_RET);
  assign ras_count_o = cnt_q;

endmodule
